// File: rtl/sdr_write_responder_if.sv
// sdr_write_responder_if: word write channel toward the SDRAM controller.
// The master issues valid/ready writes; the slave (controller) accepts them.
interface sdr_write_responder_if #(
  parameter int ADDR_W = 25
) ();
  logic [ADDR_W-2:0] mem_addr;
  logic [15:0]       mem_data;
  logic [1:0]        mem_be;
  logic              mem_wr;
  logic              mem_ready;

  modport master (
    output mem_addr,
    output mem_data,
    output mem_be,
    output mem_wr,
    input  mem_ready
  );

  modport slave (
    input  mem_addr,
    input  mem_data,
    input  mem_be,
    input  mem_wr,
    output mem_ready
  );
endinterface

// File: rtl/sdr_write_responder.sv
// sdr_write_responder: toggle req/ack byte-write responder feeding the
// SDRAM write port; byte-lane coalescing when SDR_WRITE_COALESCE_EN is set.
module sdr_write_responder #(
  parameter int ADDR_W = 25
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [15:0]           req_data,
  input  logic [1:0]            req_be,
  input  logic                  req_toggle,
  output logic                  ack_toggle,
  input  logic                  flush,
  sdr_write_responder_if.master mem,
  output logic                  idle
);
  localparam int WA_W = ADDR_W - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic            buf_valid;
  logic [WA_W-1:0] buf_addr;
  logic [15:0]     buf_data;
  logic [1:0]      buf_be;

  logic            pending;
  logic            load;
  logic            merge;
  logic            done;
  logic [WA_W-1:0] req_waddr;
  logic [7:0]      load_hi;
  logic [7:0]      load_lo;
  logic            unused_bits;

  assign pending   = req_toggle ^ ack_toggle;
  assign req_waddr = req_addr[ADDR_W-1:1];
  assign done      = (state == S_WRITE)
                   && mem.mem_ready;

  // a freshly loaded word carries only its enabled lanes
  assign load_hi = req_be[1] ? req_data[15:8] : 8'h00;
  assign load_lo = req_be[0] ? req_data[7:0]  : 8'h00;

  // byte address bit 0 only picks the lane, which be already encodes
  assign unused_bits = ^{req_addr[0], flush, merge};

`ifdef SDR_WRITE_COALESCE_EN
  logic        same_word;
  logic [1:0]  mrg_be;
  logic [7:0]  mrg_hi;
  logic [7:0]  mrg_lo;

  assign same_word = buf_valid
                   && (buf_addr == req_waddr);
  assign mrg_be    = buf_be | req_be;
  assign mrg_hi    = req_be[1] ? req_data[15:8]
                               : buf_data[15:8];
  assign mrg_lo    = req_be[0] ? req_data[7:0]
                               : buf_data[7:0];
`endif

  // state register
  always_ff @(posedge sys_clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // next state and buffer load/merge decisions
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    merge    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (pending) begin
          load = 1'b1;
`ifdef SDR_WRITE_COALESCE_EN
          if ((req_be == 2'b11) || flush)
            state_nx = S_WRITE;
          else
            state_nx = S_HOLD;
`else
          state_nx = S_WRITE;
`endif
        end
      end
      S_HOLD: begin
`ifdef SDR_WRITE_COALESCE_EN
        if (pending && same_word) begin
          merge = 1'b1;
          if ((mrg_be == 2'b11) || flush)
            state_nx = S_WRITE;
        end else if (pending || flush) begin
          state_nx = S_WRITE;
        end
`else
        state_nx = S_WRITE;
`endif
      end
      S_WRITE: begin
        if (mem.mem_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // write channel and status outputs
  always_comb begin
    mem.mem_wr   = (state == S_WRITE);
    mem.mem_addr = buf_addr;
    mem.mem_data = buf_data;
    mem.mem_be   = buf_be;
    idle         = (state == S_IDLE)
                 && !buf_valid
                 && !pending;
  end

  // word buffer: load, lane merge, release on write completion
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
      buf_be    <= '0;
    end else if (load) begin
      buf_valid <= 1'b1;
      buf_addr  <= req_waddr;
      buf_data  <= {load_hi, load_lo};
      buf_be    <= req_be;
`ifdef SDR_WRITE_COALESCE_EN
    end else if (merge) begin
      buf_data  <= {mrg_hi, mrg_lo};
      buf_be    <= mrg_be;
`endif
    end else if (done) begin
      buf_valid <= 1'b0;
    end
  end

  // acknowledge: at acceptance when coalescing, else at write completion
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      ack_toggle <= req_toggle;
`ifdef SDR_WRITE_COALESCE_EN
    end else if (load || merge) begin
      ack_toggle <= req_toggle;
`else
    end else if (done) begin
      ack_toggle <= ~ack_toggle;
`endif
    end
  end

`ifndef SYNTHESIS
  // a stalled write must stay put until the controller takes it
  a_stall_stable: assert property (
    @(posedge sys_clk) disable iff (reset)
    (mem.mem_wr && !mem.mem_ready) |=>
      (mem.mem_wr
       && $stable(mem.mem_addr)
       && $stable(mem.mem_data)
       && $stable(mem.mem_be)));
`endif
endmodule
